// File: rtl/mccu_replenish.sv
// mccu_replenish: per-core weighted contention budgets with sticky interrupts and periodic
// replenish from a shadow quota. Optional overrun counter enabled by `define MCCU_OVERRUN_EN.
module mccu_replenish #(
  parameter int DATA_WIDTH    = 32,
  parameter int WEIGHTS_WIDTH = 7,
  parameter int N_CORES       = 4,
  parameter int CORE_EVENTS   = 4,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                                           clk_i,
  input  logic                                           rstn_i,
  input  logic                                           enable_i,
  input  logic [N_CORES*CORE_EVENTS-1:0]                 events_i,
  input  logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0]   events_weights_i,
  input  logic [N_CORES*DATA_WIDTH-1:0]                  quota_i,
  input  logic [N_CORES-1:0]                             quota_load_i,
  input  logic [PERIOD_WIDTH-1:0]                        period_i,
  input  logic [N_CORES-1:0]                             irq_clear_i,
  output logic [N_CORES*DATA_WIDTH-1:0]                  quota_o,
  output logic [N_CORES*2-1:0]                           state_o,
  output logic [N_CORES-1:0]                             interruption_quota_o,
`ifdef MCCU_OVERRUN_EN
  output logic [N_CORES*DATA_WIDTH-1:0]                  overrun_o,
`endif
  output logic [PERIOD_WIDTH-1:0]                        period_cnt_o
);

  localparam int CCC_W = WEIGHTS_WIDTH + $clog2(CORE_EVENTS);
  localparam int CMP_W = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ACTIVE    = 2'b01,
    ST_EXHAUSTED = 2'b10
  } state_e;

  logic [CCC_W-1:0]        ccc_sum_d    [N_CORES];
  logic [CCC_W-1:0]        ccc_sum_q    [N_CORES];
  logic [DATA_WIDTH-1:0]   quota_d      [N_CORES];
  logic [DATA_WIDTH-1:0]   quota_q      [N_CORES];
  logic [DATA_WIDTH-1:0]   shadow_d     [N_CORES];
  logic [DATA_WIDTH-1:0]   shadow_q     [N_CORES];
  state_e                  state_d      [N_CORES];
  state_e                  state_q      [N_CORES];
  logic [N_CORES-1:0]      irq_d;
  logic [N_CORES-1:0]      irq_q;
  logic [PERIOD_WIDTH-1:0] period_cnt_d;
  logic [PERIOD_WIDTH-1:0] period_cnt_q;
  logic                    replenish_s;
  logic [CMP_W-1:0]        ccc_ext_s    [N_CORES];
  logic [CMP_W-1:0]        quota_ext_s  [N_CORES];

`ifdef MCCU_OVERRUN_EN
  logic [DATA_WIDTH-1:0]   overrun_d    [N_CORES];
  logic [DATA_WIDTH-1:0]   overrun_q    [N_CORES];

  // Saturating accumulate: any carry beyond DATA_WIDTH pins the count at all-ones.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [CMP_W-1:0]      b);
    logic [CMP_W:0] s;
    s = (CMP_W+1)'(a) + (CMP_W+1)'(b);
    if (|s[CMP_W:DATA_WIDTH]) begin
      return '1;
    end else begin
      return s[DATA_WIDTH-1:0];
    end
  endfunction
`endif

  // Weighted sum of this cycle's events per core.
  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      ccc_sum_d[c] = '0;
      for (int e = 0; e < CORE_EVENTS; e++) begin
        if (events_i[c*CORE_EVENTS+e]) begin
          ccc_sum_d[c] = ccc_sum_d[c]
                       + CCC_W'(events_weights_i[(c*CORE_EVENTS+e)*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]);
        end else begin
          ccc_sum_d[c] = ccc_sum_d[c];
        end
      end
    end
  end

  // Replenish period counter; the wrap edge is also the replenish edge.
  always_comb begin
    period_cnt_d = period_cnt_q;
    replenish_s  = 1'b0;
    if (period_i == '0) begin
      period_cnt_d = '0;
    end else if (enable_i) begin
      if (period_cnt_q >= period_i - PERIOD_WIDTH'(1)) begin
        period_cnt_d = '0;
        replenish_s  = 1'b1;
      end else begin
        period_cnt_d = period_cnt_q + PERIOD_WIDTH'(1);
      end
    end else begin
      period_cnt_d = period_cnt_q;
    end
  end

  // Per-core budget FSM: load > replenish > enabled consumption.
  always_comb begin
    for (int c = 0; c < N_CORES; c++) begin
      quota_d[c]     = quota_q[c];
      shadow_d[c]    = shadow_q[c];
      state_d[c]     = state_q[c];
      irq_d[c]       = irq_q[c];
      ccc_ext_s[c]   = CMP_W'(ccc_sum_q[c]);
      quota_ext_s[c] = CMP_W'(quota_q[c]);
`ifdef MCCU_OVERRUN_EN
      overrun_d[c]   = overrun_q[c];
`endif
      if (irq_clear_i[c]) begin
        irq_d[c] = 1'b0;
      end else begin
        irq_d[c] = irq_q[c];
      end

      if (quota_load_i[c]) begin
        quota_d[c]  = quota_i[c*DATA_WIDTH +: DATA_WIDTH];
        shadow_d[c] = quota_i[c*DATA_WIDTH +: DATA_WIDTH];
        state_d[c]  = ST_ACTIVE;
`ifdef MCCU_OVERRUN_EN
        overrun_d[c] = '0;
`endif
      end else if (replenish_s && (state_q[c] == ST_ACTIVE || state_q[c] == ST_EXHAUSTED)) begin
        quota_d[c] = shadow_q[c];
        state_d[c] = ST_ACTIVE;
`ifdef MCCU_OVERRUN_EN
        overrun_d[c] = '0;
`endif
      end else if (enable_i) begin
        case (state_q[c])
          ST_ACTIVE: begin
            if (ccc_ext_s[c] > quota_ext_s[c]) begin
              quota_d[c] = '0;
              state_d[c] = ST_EXHAUSTED;
              irq_d[c]   = 1'b1;
`ifdef MCCU_OVERRUN_EN
              overrun_d[c] = sat_add(overrun_q[c], ccc_ext_s[c] - quota_ext_s[c]);
`endif
            end else begin
              quota_d[c] = quota_q[c] - DATA_WIDTH'(ccc_sum_q[c]);
            end
          end
          ST_EXHAUSTED: begin
            quota_d[c] = '0;
`ifdef MCCU_OVERRUN_EN
            overrun_d[c] = sat_add(overrun_q[c], ccc_ext_s[c]);
`endif
          end
          ST_IDLE: begin
            quota_d[c] = quota_q[c];
          end
          default: begin
            state_d[c] = ST_IDLE;
          end
        endcase
      end else begin
        quota_d[c] = quota_q[c];
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      period_cnt_q <= '0;
      irq_q        <= '0;
      for (int c = 0; c < N_CORES; c++) begin
        ccc_sum_q[c] <= '0;
        quota_q[c]   <= '0;
        shadow_q[c]  <= '0;
        state_q[c]   <= ST_IDLE;
`ifdef MCCU_OVERRUN_EN
        overrun_q[c] <= '0;
`endif
      end
    end else begin
      period_cnt_q <= period_cnt_d;
      irq_q        <= irq_d;
      for (int c = 0; c < N_CORES; c++) begin
        ccc_sum_q[c] <= ccc_sum_d[c];
        quota_q[c]   <= quota_d[c];
        shadow_q[c]  <= shadow_d[c];
        state_q[c]   <= state_d[c];
`ifdef MCCU_OVERRUN_EN
        overrun_q[c] <= overrun_d[c];
`endif
      end
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_out
    assign quota_o[g*DATA_WIDTH +: DATA_WIDTH] = quota_q[g];
    assign state_o[g*2 +: 2]                   = state_q[g];
`ifdef MCCU_OVERRUN_EN
    assign overrun_o[g*DATA_WIDTH +: DATA_WIDTH] = overrun_q[g];
`endif
  end

  assign interruption_quota_o = irq_q;
  assign period_cnt_o         = period_cnt_q;

endmodule

// File: tb/tb_mccu_replenish.sv
// Directed, table-driven bench for mccu_replenish (core0 budget table plus hand-written
// replenish, period-counter, reset and optional overrun sequences).
module tb_mccu_replenish;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          enable_i;
  logic [15:0]   events_i;
  logic [111:0]  events_weights_i;
  logic [127:0]  quota_i;
  logic [3:0]    quota_load_i;
  logic [15:0]   period_i;
  logic [3:0]    irq_clear_i;
  logic [127:0]  quota_o;
  logic [7:0]    state_o;
  logic [3:0]    interruption_quota_o;
  logic [15:0]   period_cnt_o;
`ifdef MCCU_OVERRUN_EN
  logic [127:0]  overrun_o;
`endif

  int checks   = 0;
  int failures = 0;

  mccu_replenish dut (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .enable_i             (enable_i),
    .events_i             (events_i),
    .events_weights_i     (events_weights_i),
    .quota_i              (quota_i),
    .quota_load_i         (quota_load_i),
    .period_i             (period_i),
    .irq_clear_i          (irq_clear_i),
    .quota_o              (quota_o),
    .state_o              (state_o),
    .interruption_quota_o (interruption_quota_o),
`ifdef MCCU_OVERRUN_EN
    .overrun_o            (overrun_o),
`endif
    .period_cnt_o         (period_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ld;
    logic [31:0] qin;
    logic [3:0]  ev;
    logic        en;
    logic        clr;
    logic [31:0] exp_q;
    logic [1:0]  exp_st;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Core0 weights {3,5,0,7}; core1 event0 weight 6; core2 event0 weight 10.
    events_weights_i          = '0;
    events_weights_i[0+:7]    = 7'd3;
    events_weights_i[7+:7]    = 7'd5;
    events_weights_i[14+:7]   = 7'd0;
    events_weights_i[21+:7]   = 7'd7;
    events_weights_i[28+:7]   = 7'd6;
    events_weights_i[56+:7]   = 7'd10;

    // ld, qin, ev, en, clr -> quota, state, irq after the edge
    tbl[0]  = '{1'b1, 32'd20, 4'b1111, 1'b1, 1'b0, 32'd20, 2'b01, 1'b0};
    tbl[1]  = '{1'b0, 32'd0,  4'b1111, 1'b1, 1'b0, 32'd5,  2'b01, 1'b0};
    tbl[2]  = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b0, 32'd0,  2'b10, 1'b1};
    tbl[3]  = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b1, 32'd0,  2'b10, 1'b0};
    tbl[4]  = '{1'b1, 32'd15, 4'b1111, 1'b1, 1'b0, 32'd15, 2'b01, 1'b0};
    tbl[5]  = '{1'b0, 32'd0,  4'b0001, 1'b1, 1'b0, 32'd0,  2'b01, 1'b0};
    tbl[6]  = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b0, 32'd0,  2'b10, 1'b1};
    tbl[7]  = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b1, 32'd0,  2'b10, 1'b0};
    tbl[8]  = '{1'b1, 32'd40, 4'b0000, 1'b1, 1'b0, 32'd40, 2'b01, 1'b0};
    tbl[9]  = '{1'b0, 32'd0,  4'b1111, 1'b0, 1'b0, 32'd40, 2'b01, 1'b0};
    tbl[10] = '{1'b0, 32'd0,  4'b1111, 1'b0, 1'b0, 32'd40, 2'b01, 1'b0};
    tbl[11] = '{1'b1, 32'd50, 4'b0000, 1'b0, 1'b0, 32'd50, 2'b01, 1'b0};
    tbl[12] = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b0, 32'd50, 2'b01, 1'b0};
    tbl[13] = '{1'b0, 32'd0,  4'b0001, 1'b1, 1'b0, 32'd50, 2'b01, 1'b0};
    tbl[14] = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b0, 32'd47, 2'b01, 1'b0};
    tbl[15] = '{1'b1, 32'd2,  4'b1111, 1'b1, 1'b0, 32'd2,  2'b01, 1'b0};
    tbl[16] = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b1, 32'd0,  2'b10, 1'b1};
    tbl[17] = '{1'b0, 32'd0,  4'b0000, 1'b1, 1'b1, 32'd0,  2'b10, 1'b0};

    rstn_i       = 1'b0;
    enable_i     = 1'b0;
    events_i     = '0;
    quota_i      = '0;
    quota_load_i = '0;
    period_i     = '0;
    irq_clear_i  = '0;

    #3;
    check("reset_quota",  {32'd0, quota_o[31:0]}, 64'd0);
    check("reset_state",  {56'd0, state_o}, 64'd0);
    check("reset_irq",    {60'd0, interruption_quota_o}, 64'd0);
    check("reset_pcnt",   {48'd0, period_cnt_o}, 64'd0);
    #4;
    rstn_i = 1'b1;
    step();

    // Core0 budget table, period disabled.
    for (int i = 0; i < 18; i++) begin
      quota_load_i[0] = tbl[i].ld;
      quota_i[31:0]   = tbl[i].qin;
      events_i[3:0]   = tbl[i].ev;
      enable_i        = tbl[i].en;
      irq_clear_i[0]  = tbl[i].clr;
      step();
      check($sformatf("tbl%0d_quota", i), {32'd0, quota_o[31:0]}, {32'd0, tbl[i].exp_q});
      check($sformatf("tbl%0d_state", i), {62'd0, state_o[1:0]}, {62'd0, tbl[i].exp_st});
      check($sformatf("tbl%0d_irq", i),   {63'd0, interruption_quota_o[0]}, {63'd0, tbl[i].exp_irq});
      check($sformatf("tbl%0d_pcnt", i),  {48'd0, period_cnt_o}, 64'd0);
    end
    quota_load_i = '0;
    events_i     = '0;
    irq_clear_i  = '0;
    enable_i     = 1'b1;

    // Replenish on core1: load 10, consume 6 per cycle, period 4.
    quota_load_i[1] = 1'b1;
    quota_i[63:32]  = 32'd10;
    events_i[7:4]   = 4'b0001;
    period_i        = 16'd4;
    step();
    quota_load_i[1] = 1'b0;
    check("rep_load_quota", {32'd0, quota_o[63:32]}, 64'd10);
    check("rep_load_pcnt",  {48'd0, period_cnt_o}, 64'd1);
    step();
    check("rep_dec_quota",  {32'd0, quota_o[63:32]}, 64'd4);
    check("rep_dec_pcnt",   {48'd0, period_cnt_o}, 64'd2);
    step();
    check("rep_exh_quota",  {32'd0, quota_o[63:32]}, 64'd0);
    check("rep_exh_state",  {62'd0, state_o[3:2]}, 64'd2);
    check("rep_exh_irq",    {63'd0, interruption_quota_o[1]}, 64'd1);
    check("rep_exh_pcnt",   {48'd0, period_cnt_o}, 64'd3);
    events_i[7:4] = 4'b0000;
    step();
    check("rep_wrap_quota", {32'd0, quota_o[63:32]}, 64'd10);
    check("rep_wrap_state", {62'd0, state_o[3:2]}, 64'd1);
    check("rep_wrap_irq",   {63'd0, interruption_quota_o[1]}, 64'd1);
    check("rep_wrap_pcnt",  {48'd0, period_cnt_o}, 64'd0);
    step();
    check("rep_hold_quota", {32'd0, quota_o[63:32]}, 64'd10);
    check("rep_hold_pcnt",  {48'd0, period_cnt_o}, 64'd1);
    irq_clear_i[1] = 1'b1;
    step();
    irq_clear_i[1] = 1'b0;
    check("rep_clr_irq",    {63'd0, interruption_quota_o[1]}, 64'd0);
    check("rep_clr_pcnt",   {48'd0, period_cnt_o}, 64'd2);

    // Period edge cases: period 1, counting, enable low, period lowered below count.
    period_i = 16'd1;
    step();
    check("per1_a", {48'd0, period_cnt_o}, 64'd0);
    step();
    check("per1_b", {48'd0, period_cnt_o}, 64'd0);
    period_i = 16'd8;
    for (int k = 0; k < 5; k++) step();
    check("per8_count", {48'd0, period_cnt_o}, 64'd5);
    enable_i = 1'b0;
    step();
    check("per_en_low", {48'd0, period_cnt_o}, 64'd5);
    enable_i = 1'b1;
    period_i = 16'd3;
    step();
    check("per_lowered", {48'd0, period_cnt_o}, 64'd0);
    period_i = 16'd0;
    step();

`ifdef MCCU_OVERRUN_EN
    // Overrun on core2: quota 4, ccc_sum 10 per cycle.
    quota_load_i[2] = 1'b1;
    quota_i[95:64]  = 32'd4;
    events_i[11:8]  = 4'b0001;
    step();
    quota_load_i[2] = 1'b0;
    check("ovr_load", {32'd0, overrun_o[95:64]}, 64'd0);
    step();
    check("ovr_exh",   {32'd0, overrun_o[95:64]}, 64'd6);
    check("ovr_state", {62'd0, state_o[5:4]}, 64'd2);
    step();
    check("ovr_acc1", {32'd0, overrun_o[95:64]}, 64'd16);
    step();
    check("ovr_acc2", {32'd0, overrun_o[95:64]}, 64'd26);
    quota_load_i[2] = 1'b1;
    events_i[11:8]  = 4'b0000;
    step();
    quota_load_i[2] = 1'b0;
    check("ovr_clear", {32'd0, overrun_o[95:64]}, 64'd0);
`endif

    // Asynchronous reset between edges.
    quota_load_i[0] = 1'b1;
    quota_i[31:0]   = 32'd100;
    period_i        = 16'd8;
    step();
    quota_load_i[0] = 1'b0;
    check("pre_rst_quota", {32'd0, quota_o[31:0]}, 64'd100);
    check("pre_rst_pcnt",  {48'd0, period_cnt_o}, 64'd1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("async_rst_quota", {32'd0, quota_o[31:0]}, 64'd0);
    check("async_rst_state", {56'd0, state_o}, 64'd0);
    check("async_rst_irq",   {60'd0, interruption_quota_o}, 64'd0);
    check("async_rst_pcnt",  {48'd0, period_cnt_o}, 64'd0);
    period_i = 16'd0;
    #3;
    rstn_i = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
